// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station slice: ROB id width and datapath widths.
package rs_alu_pkg;
   localparam int unsigned ROB_W = 4;
   localparam int unsigned WT_W  = 5;
   localparam int unsigned XLEN  = 32;
endpackage

// File: rtl/rs_alu_pick.sv
// Lowest-index priority encoder: returns the first set request bit and a found flag.
module rs_alu_pick #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]         req,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);
   localparam int unsigned IDX_W = $clog2(N);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched micro-ops, wakes operands from the ALU/LSB
// result buses and issues one ready entry per cycle. Optional: RS_ALU_FASTWAKE_EN.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int unsigned RS_SIZE  = 8,
   parameter int unsigned ROB_ID_W = ROB_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                clear,
   input  logic                disp_valid,
   input  logic [WT_W-1:0]     disp_work_type,
   input  logic [ROB_ID_W-1:0] disp_rob_id,
   input  logic [XLEN-1:0]     disp_v1,
   input  logic [XLEN-1:0]     disp_v2,
   input  logic                disp_p1,
   input  logic                disp_p2,
   input  logic [ROB_ID_W-1:0] disp_q1,
   input  logic [ROB_ID_W-1:0] disp_q2,
   output logic                full,
   input  logic                alu_cdb_ready,
   input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
   input  logic [XLEN-1:0]     alu_cdb_value,
   input  logic                lsb_cdb_ready,
   input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
   input  logic [XLEN-1:0]     lsb_cdb_value,
   output logic                alu_valid,
   output logic [WT_W-1:0]     alu_work_type,
   output logic [XLEN-1:0]     alu_r1,
   output logic [XLEN-1:0]     alu_r2,
   output logic [ROB_ID_W-1:0] alu_rob_id
);
   localparam int unsigned IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0]  busy, p1, p2;
   logic [WT_W-1:0]     wt  [RS_SIZE];
   logic [ROB_ID_W-1:0] rob [RS_SIZE];
   logic [ROB_ID_W-1:0] q1  [RS_SIZE];
   logic [ROB_ID_W-1:0] q2  [RS_SIZE];
   logic [XLEN-1:0]     v1  [RS_SIZE];
   logic [XLEN-1:0]     v2  [RS_SIZE];

   logic [RS_SIZE-1:0]  hit1, hit2, ready;
   logic [XLEN-1:0]     wv1 [RS_SIZE];
   logic [XLEN-1:0]     wv2 [RS_SIZE];
   logic [XLEN-1:0]     iv1 [RS_SIZE];
   logic [XLEN-1:0]     iv2 [RS_SIZE];

   logic [IDX_W-1:0]    free_idx, sel_idx;
   logic                free_found, sel_found, disp_we;
   logic                da1, dl1, da2, dl2, dp1, dp2;
   logic [XLEN-1:0]     dv1, dv2;

   assign full    = &busy;
   assign disp_we = disp_valid & free_found;

   // Same-cycle CDB capture for dispatched operands, so a broadcast is never missed.
   assign da1 = alu_cdb_ready && (disp_q1 == alu_cdb_rob_id);
   assign dl1 = lsb_cdb_ready && (disp_q1 == lsb_cdb_rob_id);
   assign da2 = alu_cdb_ready && (disp_q2 == alu_cdb_rob_id);
   assign dl2 = lsb_cdb_ready && (disp_q2 == lsb_cdb_rob_id);
   assign dp1 = disp_p1 & ~(da1 | dl1);
   assign dp2 = disp_p2 & ~(da2 | dl2);
   assign dv1 = !disp_p1 ? disp_v1 : (da1 ? alu_cdb_value : (dl1 ? lsb_cdb_value : disp_v1));
   assign dv2 = !disp_p2 ? disp_v2 : (da2 ? alu_cdb_value : (dl2 ? lsb_cdb_value : disp_v2));

   // Per-entry wakeup match (ALU bus wins on an id tie) and readiness.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         hit1[i] = busy[i] & p1[i] &
                   ((alu_cdb_ready && (q1[i] == alu_cdb_rob_id)) ||
                    (lsb_cdb_ready && (q1[i] == lsb_cdb_rob_id)));
         hit2[i] = busy[i] & p2[i] &
                   ((alu_cdb_ready && (q2[i] == alu_cdb_rob_id)) ||
                    (lsb_cdb_ready && (q2[i] == lsb_cdb_rob_id)));
         wv1[i]  = (alu_cdb_ready && (q1[i] == alu_cdb_rob_id)) ? alu_cdb_value : lsb_cdb_value;
         wv2[i]  = (alu_cdb_ready && (q2[i] == alu_cdb_rob_id)) ? alu_cdb_value : lsb_cdb_value;
`ifdef RS_ALU_FASTWAKE_EN
         ready[i] = busy[i] & (~p1[i] | hit1[i]) & (~p2[i] | hit2[i]);
         iv1[i]   = hit1[i] ? wv1[i] : v1[i];
         iv2[i]   = hit2[i] ? wv2[i] : v2[i];
`else
         ready[i] = busy[i] & ~p1[i] & ~p2[i];
         iv1[i]   = v1[i];
         iv2[i]   = v2[i];
`endif
      end
   end

   rs_alu_pick #(.N(RS_SIZE)) u_free_pick (
      .req   (~busy),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_alu_pick #(.N(RS_SIZE)) u_ready_pick (
      .req   (ready),
      .idx   (sel_idx),
      .found (sel_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy          <= '0;
         p1            <= '0;
         p2            <= '0;
         alu_valid     <= 1'b0;
         alu_work_type <= '0;
         alu_r1        <= '0;
         alu_r2        <= '0;
         alu_rob_id    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            wt[i]  <= '0;
            rob[i] <= '0;
            q1[i]  <= '0;
            q2[i]  <= '0;
            v1[i]  <= '0;
            v2[i]  <= '0;
         end
      end else if (rdy) begin
         if (clear) begin
            busy      <= '0;
            alu_valid <= 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (hit1[i]) begin
                  p1[i] <= 1'b0;
                  v1[i] <= wv1[i];
               end
               if (hit2[i]) begin
                  p2[i] <= 1'b0;
                  v2[i] <= wv2[i];
               end
            end
            alu_valid <= sel_found;
            if (sel_found) begin
               busy[sel_idx] <= 1'b0;
               alu_work_type <= wt[sel_idx];
               alu_r1        <= iv1[sel_idx];
               alu_r2        <= iv2[sel_idx];
               alu_rob_id    <= rob[sel_idx];
            end
            // Free slot comes from registered busy, so it never collides with the issuing entry.
            if (disp_we) begin
               busy[free_idx] <= 1'b1;
               wt[free_idx]   <= disp_work_type;
               rob[free_idx]  <= disp_rob_id;
               p1[free_idx]   <= dp1;
               p2[free_idx]   <= dp2;
               q1[free_idx]   <= disp_q1;
               q2[free_idx]   <= disp_q2;
               v1[free_idx]   <= dv1;
               v2[free_idx]   <= dv2;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && !clear) begin
         assert (!(disp_valid && full));
      end
   end
endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed vector table, corner sequences and a
// randomized run against a scoreboard of outstanding micro-ops.
module tb_rs_alu;
   import rs_alu_pkg::*;

   logic             clk, rst, rdy, clear;
   logic             disp_valid;
   logic [WT_W-1:0]  disp_work_type;
   logic [ROB_W-1:0] disp_rob_id, disp_q1, disp_q2;
   logic [XLEN-1:0]  disp_v1, disp_v2;
   logic             disp_p1, disp_p2, full;
   logic             alu_cdb_ready, lsb_cdb_ready;
   logic [ROB_W-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
   logic [XLEN-1:0]  alu_cdb_value, lsb_cdb_value;
   logic             alu_valid;
   logic [WT_W-1:0]  alu_work_type;
   logic [XLEN-1:0]  alu_r1, alu_r2;
   logic [ROB_W-1:0] alu_rob_id;

   int checks = 0;
   int failures = 0;

   rs_alu #(.RS_SIZE(8), .ROB_ID_W(ROB_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .disp_valid(disp_valid), .disp_work_type(disp_work_type), .disp_rob_id(disp_rob_id),
      .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_p1(disp_p1), .disp_p2(disp_p2),
      .disp_q1(disp_q1), .disp_q2(disp_q2), .full(full),
      .alu_cdb_ready(alu_cdb_ready), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
      .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
      .alu_valid(alu_valid), .alu_work_type(alu_work_type), .alu_r1(alu_r1), .alu_r2(alu_r2),
      .alu_rob_id(alu_rob_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [4:0]  wt;
      logic [3:0]  rob;
      logic [31:0] v1, v2;
      logic        p1, p2;
      logic [3:0]  q1, q2;
      logic        ae;
      logic [3:0]  aid;
      logic [31:0] aval;
      logic        le;
      logic [3:0]  lid;
      logic [31:0] lval;
      logic [31:0] e1, e2;
   } vec_t;

   // Scoreboard indexed by ROB id (0..7) of outstanding micro-ops.
   bit          m_busy [8];
   logic [4:0]  m_wt   [8];
   logic [31:0] m_v1   [8];
   logic [31:0] m_v2   [8];
   bit          m_k1   [8];
   bit          m_k2   [8];
   logic [3:0]  m_t1   [8];
   logic [3:0]  m_t2   [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = 1'b0; disp_work_type = '0; disp_rob_id = '0;
      disp_v1 = '0; disp_v2 = '0; disp_p1 = 1'b0; disp_p2 = 1'b0; disp_q1 = '0; disp_q2 = '0;
      alu_cdb_ready = 1'b0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
      lsb_cdb_ready = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
      clear = 1'b0;
   endtask

   task automatic disp(input logic [4:0] wt, input logic [3:0] rob, input logic [31:0] v1,
                       input logic [31:0] v2, input logic p1, input logic [3:0] q1,
                       input logic p2, input logic [3:0] q2);
      disp_valid = 1'b1; disp_work_type = wt; disp_rob_id = rob;
      disp_v1 = v1; disp_v2 = v2; disp_p1 = p1; disp_q1 = q1; disp_p2 = p2; disp_q2 = q2;
   endtask

   task automatic acdb(input logic [3:0] id, input logic [31:0] val);
      alu_cdb_ready = 1'b1; alu_cdb_rob_id = id; alu_cdb_value = val;
   endtask

   task automatic lcdb(input logic [3:0] id, input logic [31:0] val);
      lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = id; lsb_cdb_value = val;
   endtask

   function automatic int occ();
      int n = 0;
      for (int i = 0; i < 8; i++) if (m_busy[i]) n++;
      return n;
   endfunction

   // One randomized cycle: drive, clock, then update the scoreboard and check any issue.
   task automatic rand_cycle(input bit drain, input int c);
      bit          r, de, ae, le;
      logic [3:0]  id, ta, tl;
      logic [31:0] av, lv;
      logic [4:0]  wt;
      logic [31:0] v1, v2;
      bit          p1, p2;
      logic [3:0]  q1, q2;
      int          start;
      idle();
      r  = drain ? 1'b1 : ($urandom_range(0, 9) != 0);
      de = !drain && (occ() < 8) && ($urandom_range(0, 9) < 6);
      id = '0;
      if (de) begin
         start = $urandom_range(0, 7);
         for (int k = 0; k < 8; k++)
            if (!m_busy[(start + k) % 8]) id = 4'((start + k) % 8);
         wt = 5'($urandom); v1 = $urandom; v2 = $urandom;
         p1 = ($urandom_range(0, 1) == 1); p2 = ($urandom_range(0, 1) == 1);
         q1 = 4'(8 + $urandom_range(0, 7)); q2 = 4'(8 + $urandom_range(0, 7));
         disp(wt, id, v1, v2, p1, q1, p2, q2);
      end
      if (drain) begin
         ae = 1'b1; ta = 4'(8 + (c % 8));
         le = 1'b1; tl = 4'(8 + ((c + 4) % 8));
      end else begin
         ae = ($urandom_range(0, 9) < 4); ta = 4'(8 + $urandom_range(0, 7));
         le = ($urandom_range(0, 9) < 4); tl = 4'(8 + ((ta - 8 + 1 + $urandom_range(0, 6)) % 8));
      end
      av = $urandom; lv = $urandom;
      if (ae) acdb(ta, av);
      if (le) lcdb(tl, lv);
      rdy = r;
      step();
      if (r) begin
         if (de) begin
            m_busy[id] = 1'b1; m_wt[id] = wt;
            m_v1[id] = v1; m_v2[id] = v2; m_k1[id] = !p1; m_k2[id] = !p2;
            m_t1[id] = q1; m_t2[id] = q2;
         end
         for (int i = 0; i < 8; i++) begin
            if (m_busy[i] && !m_k1[i] && ae && m_t1[i] == ta) begin m_k1[i] = 1'b1; m_v1[i] = av; end
            else if (m_busy[i] && !m_k1[i] && le && m_t1[i] == tl) begin m_k1[i] = 1'b1; m_v1[i] = lv; end
            if (m_busy[i] && !m_k2[i] && ae && m_t2[i] == ta) begin m_k2[i] = 1'b1; m_v2[i] = av; end
            else if (m_busy[i] && !m_k2[i] && le && m_t2[i] == tl) begin m_k2[i] = 1'b1; m_v2[i] = lv; end
         end
         if (alu_valid) begin
            checks++;
            if (alu_rob_id >= 4'd8 || !m_busy[alu_rob_id[2:0]]) begin
               failures++;
               $display("FAIL rand_issue_id actual=%0d required=an outstanding rob id", alu_rob_id);
            end else begin
               chk("rand_operands_known", 32'(m_k1[alu_rob_id[2:0]] && m_k2[alu_rob_id[2:0]]), 32'd1);
               chk("rand_work_type", 32'(alu_work_type), 32'(m_wt[alu_rob_id[2:0]]));
               chk("rand_r1", alu_r1, m_v1[alu_rob_id[2:0]]);
               chk("rand_r2", alu_r2, m_v2[alu_rob_id[2:0]]);
               m_busy[alu_rob_id[2:0]] = 1'b0;
            end
         end
         chk("rand_full", 32'(full), 32'(occ() == 8));
      end
      rdy = 1'b1;
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{5'd0,  4'd3,  32'd5,    32'd7,        1'b0, 1'b0, 4'd0,  4'd0,
                  1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'd5,      32'd7};
      vecs[1] = '{5'h08, 4'd6,  32'd100,  32'd1,        1'b0, 1'b0, 4'd0,  4'd0,
                  1'b0, 4'd0,  32'd0,      1'b0, 4'd0,  32'd0,      32'd100,    32'd1};
      vecs[2] = '{5'h11, 4'd2,  32'd9,    32'd0,        1'b0, 1'b1, 4'd0,  4'd5,
                  1'b0, 4'd0,  32'd0,      1'b1, 4'd5,  32'h100,    32'd9,      32'h100};
      vecs[3] = '{5'h04, 4'd1,  32'h55,   32'h66,       1'b1, 1'b1, 4'd11, 4'd12,
                  1'b1, 4'd11, 32'hdead,   1'b1, 4'd12, 32'hbeef,   32'hdead,   32'hbeef};
      vecs[4] = '{5'h02, 4'd14, 32'd77,   32'hffffffff, 1'b1, 1'b0, 4'd13, 4'd0,
                  1'b1, 4'd13, 32'd42,     1'b0, 4'd0,  32'd0,      32'd42,     32'hffffffff};
      vecs[5] = '{5'h07, 4'd15, 32'd0,    32'd0,        1'b1, 1'b1, 4'd8,  4'd8,
                  1'b1, 4'd8,  32'h1234,   1'b1, 4'd9,  32'h9999,   32'h1234,   32'h1234};

      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      rst = 1'b1; rdy = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_alu_valid", 32'(alu_valid), 32'd0);
      chk("reset_work_type", 32'(alu_work_type), 32'd0);
      chk("reset_r1", alu_r1, 32'd0);
      chk("reset_r2", alu_r2, 32'd0);
      chk("reset_rob_id", 32'(alu_rob_id), 32'd0);
      chk("reset_full", 32'(full), 32'd0);
      rst = 1'b0;
      step();

      // Table: dispatch with optional same-cycle CDB capture, issue one edge later.
      for (int i = 0; i < 6; i++) begin
         idle();
         disp(vecs[i].wt, vecs[i].rob, vecs[i].v1, vecs[i].v2,
              vecs[i].p1, vecs[i].q1, vecs[i].p2, vecs[i].q2);
         if (vecs[i].ae) acdb(vecs[i].aid, vecs[i].aval);
         if (vecs[i].le) lcdb(vecs[i].lid, vecs[i].lval);
         step();
         idle();
         chk("vec_no_early_issue", 32'(alu_valid), 32'd0);
         step();
         chk("vec_valid", 32'(alu_valid), 32'd1);
         chk("vec_rob_id", 32'(alu_rob_id), 32'(vecs[i].rob));
         chk("vec_work_type", 32'(alu_work_type), 32'(vecs[i].wt));
         chk("vec_r1", alu_r1, vecs[i].e1);
         chk("vec_r2", alu_r2, vecs[i].e2);
         step();
         chk("vec_valid_drop", 32'(alu_valid), 32'd0);
      end

      // Pending operand woken by the ALU bus.
      idle();
      disp(5'd0, 4'd4, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0);
      step();
      idle();
      chk("dep_wait", 32'(alu_valid), 32'd0);
      acdb(4'd3, 32'd12);
      step();
      idle();
`ifndef RS_ALU_FASTWAKE_EN
      chk("dep_no_issue_on_capture", 32'(alu_valid), 32'd0);
      step();
`endif
      chk("dep_valid", 32'(alu_valid), 32'd1);
      chk("dep_r1", alu_r1, 32'd12);
      chk("dep_r2", alu_r2, 32'd1);
      chk("dep_rob_id", 32'(alu_rob_id), 32'd4);
      step();

      // Fill all entries waiting on rob 9, then release them together.
      for (int k = 0; k < 8; k++) begin
         idle();
         disp(5'd0, 4'(k), 32'd0, 32'(k), 1'b1, 4'd9, 1'b0, 4'd0);
         step();
      end
      idle();
      chk("fill_full", 32'(full), 32'd1);
      acdb(4'd9, 32'h900);
      step();
      idle();
`ifndef RS_ALU_FASTWAKE_EN
      chk("fill_no_issue_on_capture", 32'(alu_valid), 32'd0);
      step();
`endif
      for (int k = 0; k < 8; k++) begin
         chk("fill_valid", 32'(alu_valid), 32'd1);
         chk("fill_order", 32'(alu_rob_id), 32'(k));
         chk("fill_r1", alu_r1, 32'h900);
         chk("fill_r2", alu_r2, 32'(k));
         if (k == 0) chk("fill_full_after_issue", 32'(full), 32'd0);
         step();
      end
      chk("fill_drained", 32'(alu_valid), 32'd0);

      // Flush with entries waiting and an issue in flight.
      for (int k = 0; k < 7; k++) begin
         idle();
         disp(5'd0, 4'(k), 32'd0, 32'd0, 1'b1, 4'd10, 1'b0, 4'd0);
         step();
      end
      idle();
      disp(5'd2, 4'd7, 32'h70, 32'h71, 1'b0, 4'd0, 1'b0, 4'd0);
      step();
      idle();
      chk("clr_full_before", 32'(full), 32'd1);
      step();
      chk("clr_valid_before", 32'(alu_valid), 32'd1);
      chk("clr_rob_before", 32'(alu_rob_id), 32'd7);
      clear = 1'b1;
      step();
      idle();
      chk("clr_valid", 32'(alu_valid), 32'd0);
      chk("clr_full", 32'(full), 32'd0);
      acdb(4'd10, 32'd1);
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         chk("clr_no_stale_issue", 32'(alu_valid), 32'd0);
         step();
      end
      clear = 1'b1;
      disp(5'd0, 4'd5, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
      step();
      idle();
      step();
      chk("clr_drops_dispatch", 32'(alu_valid), 32'd0);

      // Stall with a ready entry: everything frozen, then issue on the first rdy edge.
      disp(5'd1, 4'd6, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0);
      step();
      idle();
      rdy = 1'b0;
      disp(5'd0, 4'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_valid", 32'(alu_valid), 32'd0);
         chk("stall_rob", 32'(alu_rob_id), 32'd7);
         chk("stall_r1", alu_r1, 32'h70);
      end
      idle();
      rdy = 1'b1;
      step();
      chk("stall_resume_valid", 32'(alu_valid), 32'd1);
      chk("stall_resume_rob", 32'(alu_rob_id), 32'd6);
      chk("stall_resume_wt", 32'(alu_work_type), 32'd1);
      chk("stall_resume_r1", alu_r1, 32'h11);
      chk("stall_resume_r2", alu_r2, 32'h22);
      step();
      chk("stall_ignored_dispatch", 32'(alu_valid), 32'd0);

      // Randomized traffic, then drain every tag.
      for (int c = 0; c < 3000; c++) rand_cycle(1'b0, c);
      for (int c = 0; c < 400 && occ() > 0; c++) rand_cycle(1'b1, c);
      chk("drain_empty", 32'(occ()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rs_alu.md
# rs_alu

- ALU reservation station: the issuing end of the ALU request interface (`valid`/`work_type`/`r1`/`r2`/`inst_rob_id`).
- Buffers dispatched integer and branch-compare micro-ops until both operands are known.
- Wakes operands by snooping the ALU and LSB result buses.
- Issues at most one ready entry per cycle into the `alu` block; sits between decoder/ROB dispatch and `alu`.

## Interface
Parameters:
- RS_SIZE, 8, number of entries (≥2)
- ROB_ID_W, `` `robsize``, ROB id width (from shared constants)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global clock enable; low = hold all state
- clear  in  1  pipeline flush (mispredict)
- disp_valid  in  1  dispatch request
- disp_work_type  in  5  ALU opcode, same encoding as ALU `work_type`
- disp_rob_id  in  ROB_ID_W  destination ROB id
- disp_v1 / disp_v2  in  32  operand values, meaningful when not pending
- disp_p1 / disp_p2  in  1  operand pending
- disp_q1 / disp_q2  in  ROB_ID_W  producer ROB id when pending
- full  out  1  no free entry
- alu_cdb_ready, alu_cdb_rob_id, alu_cdb_value  in  1/ROB_ID_W/32  ALU result bus
- lsb_cdb_ready, lsb_cdb_rob_id, lsb_cdb_value  in  1/ROB_ID_W/32  LSB result bus
- alu_valid  out  1  issue strobe to ALU
- alu_work_type  out  5
- alu_r1 / alu_r2  out  32
- alu_rob_id  out  ROB_ID_W

## Operation
- Entry state: busy, work_type, rob_id, v1, v2, p1, p2, q1, q2.
- Ready entry: busy & !p1 & !p2.
- Dispatch (disp_valid & !full): write the lowest-index free entry.
  - An entry issued this cycle is not free until the next cycle.
  - If a disp operand is pending and its q matches a valid CDB this cycle, capture the CDB value and store the operand as not pending (no lost wakeup).
- Wakeup: for every busy entry with pN=1 and qN == a valid CDB rob_id, latch the value and clear pN.
  - ALU bus takes priority if both buses carry the same id; the ROB never produces that case.
- Select: lowest-index ready entry.
  - Load its fields into the issue registers, set alu_valid=1, clear its busy.
  - No ready entry: alu_valid=0, other issue outputs hold.
- full: combinational; 1 when all entries are busy in registered state. disp_valid while full is ignored and is an assertion failure.
- clear (when rdy=1): all busy=0 and alu_valid=0 at the next edge; a dispatch in the same cycle is dropped; highest priority after rst.
- rdy=0: no state changes; CDB and dispatch are ignored (upstream also stalls); alu_valid holds its value.
- rst: all busy=0, alu_valid=0, alu_work_type=0, alu_r1=0, alu_r2=0, alu_rob_id=0; full=0.

## Timing
- Dispatch with no dependencies:
  - entry written at edge E0;
  - issue registers loaded at E1 (alu_valid=1 during E1–E2);
  - ALU samples at E2 and drives its result from E2.
- Pending operand:
  - CDB match sampled at edge W;
  - issue at W+1 (W with RS_ALU_FASTWAKE_EN).
- Throughput: one issue per cycle. Back-to-back ready entries issue on consecutive edges with alu_valid held high.
- No combinational path from inputs to alu_* outputs; full depends on registered state only.

## Configuration
- RS_ALU_FASTWAKE_EN defined:
  - ready evaluation also counts an operand as available when it matches a valid CDB in the current cycle;
  - the issued operand is muxed directly from the CDB value;
  - wakeup-to-issue latency is 0 extra edges.
- Undefined: only registered p1/p2 are considered, adding one cycle of wakeup-to-issue latency and shortening the critical path.

## Structure
- Shared constants (`` `robsize``, work_type field positions: bit 4 branch-compare, bit 3 sub/sra, bits 2:0 funct) come from the shared constants include; do not redefine them locally.
- One sub-module, `rs_alu_pick`: parameterised lowest-index priority encoder returning index plus found flag. Instantiated twice: free-slot pick and ready-entry pick.

## Test plan
- After rst, dispatch ADD (work_type 0) rob 3, v1=5, v2=7, no pending -> one edge later alu_valid=1, alu_r1=5, alu_r2=7, alu_rob_id=3; ALU value 12.
- Dispatch rob 4 with p1=1, q1=3, v2=1; drive alu_cdb rob 3 value 12 -> entry issues with alu_r1=12, alu_r2=1:
  - one edge after capture without RS_ALU_FASTWAKE_EN;
  - on the capture edge with it.
- Dispatch with p2=1, q2=5 in the same cycle lsb_cdb broadcasts rob 5 value 0x100 -> entry issues next edge with alu_r2=0x100, no hang.
- Fill all 8 entries with p1=1, q1=9 -> full=1. Broadcast rob 9 -> entries issue in index order 0..7 on 8 consecutive edges; full=0 after the first issue.
- With 3 busy entries and alu_valid=1, pulse clear -> next edge alu_valid=0, full=0; later CDB matches cause no issue.
- Hold rdy=0 for 3 cycles with a ready entry pending -> all outputs frozen; issue resumes on the first edge with rdy=1.
